// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers ALU and LSU results and round-robins them onto the single
// register-file write port. Optional operand bypass ports are enabled by WB_FORWARD_EN.
module writeback_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
`ifdef WB_FORWARD_EN
  input  logic [4:0]  read_address1,
  input  logic [4:0]  read_address2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
`endif
  output logic        reg_wr_en,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic [31:0] pending_mask,
  output logic        idle
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // Index 0 is the ALU source, index 1 the LSU source.
  entry_t [DEPTH-1:0] mem_q [2];
  entry_t [DEPTH-1:0] mem_d [2];
  logic   [PW-1:0]    wptr_q [2];
  logic   [PW-1:0]    wptr_d [2];
  logic   [PW-1:0]    rptr_q [2];
  logic   [PW-1:0]    rptr_d [2];
  logic   [CW-1:0]    cnt_q  [2];
  logic   [CW-1:0]    cnt_d  [2];

  src_e        last_grant_q, last_grant_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic   ready    [2];
  logic   push     [2];
  logic   pop      [2];
  logic   nonempty [2];
  entry_t in_entry [2];
  entry_t head     [2];

  logic   gnt_any;
  src_e   gnt_src;
  entry_t gnt_entry;

  always_comb begin
    in_entry[0] = {alu_rd, alu_data};
    in_entry[1] = {lsu_rd, lsu_data};
    for (int s = 0; s < 2; s++) begin
      ready[s]    = (cnt_q[s] != FULL);
      nonempty[s] = (cnt_q[s] != '0);
      head[s]     = mem_q[s][rptr_q[s]];
    end
    // x0 results complete the handshake but are never stored.
    push[0] = alu_valid && ready[0] && (alu_rd != 5'd0);
    push[1] = lsu_valid && ready[1] && (lsu_rd != 5'd0);
  end

  always_comb begin
    gnt_any = nonempty[0] || nonempty[1];
    if (nonempty[0] && nonempty[1]) begin
      gnt_src = (last_grant_q == SRC_LSU) ? SRC_ALU : SRC_LSU;
    end else if (nonempty[0]) begin
      gnt_src = SRC_ALU;
    end else begin
      gnt_src = SRC_LSU;
    end
    pop[0]    = gnt_any && (gnt_src == SRC_ALU);
    pop[1]    = gnt_any && (gnt_src == SRC_LSU);
    gnt_entry = (gnt_src == SRC_ALU) ? head[0] : head[1];
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      mem_d[s]  = mem_q[s];
      wptr_d[s] = wptr_q[s];
      rptr_d[s] = rptr_q[s];
      cnt_d[s]  = cnt_q[s];
      if (push[s]) begin
        mem_d[s][wptr_q[s]] = in_entry[s];
        wptr_d[s]           = wptr_q[s] + PW'(1);
      end
      if (pop[s]) begin
        rptr_d[s] = rptr_q[s] + PW'(1);
      end
      if (push[s] && !pop[s]) begin
        cnt_d[s] = cnt_q[s] + CW'(1);
      end else if (!push[s] && pop[s]) begin
        cnt_d[s] = cnt_q[s] - CW'(1);
      end
    end

    wr_en_d      = gnt_any;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    if (gnt_any) begin
      waddr_d      = gnt_entry.rd;
      wdata_d      = gnt_entry.data;
      last_grant_d = gnt_src;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      last_grant_q <= SRC_LSU;
      wr_en_q      <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Storage carries no reset; occupancy is defined solely by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      mem_q[s] <= mem_d[s];
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int s = 0; s < 2; s++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) < cnt_q[s]) begin
          pending_mask[mem_q[s][rptr_q[s] + PW'(i)].rd] = 1'b1;
        end
      end
    end
    if (wr_en_q) begin
      pending_mask[waddr_q] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  assign alu_ready     = ready[0];
  assign lsu_ready     = ready[1];
  assign reg_wr_en     = wr_en_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign idle          = !nonempty[0] && !nonempty[1] && !wr_en_q;

`ifdef WB_FORWARD_EN
  // Bypass the value the register file commits at the coming edge.
  always_comb begin
    fwd_hit1  = wr_en_q && (waddr_q == read_address1) && (read_address1 != 5'd0);
    fwd_hit2  = wr_en_q && (waddr_q == read_address2) && (read_address2 != 5'd0);
    fwd_data1 = fwd_hit1 ? wdata_q : '0;
    fwd_data2 = fwd_hit2 ? wdata_q : '0;
  end
`endif

endmodule
